// File: rtl/mccoy_prog_feeder_pkg.sv
// Shared definitions for the McCoy program feeder: state encoding,
// McCoy word widths and the default fill word.
package mccoy_prog_feeder_pkg;

  localparam int MCCOY_IW = 6;
  localparam int MCCOY_AW = 6;

  localparam logic [MCCOY_IW-1:0] FILL_DEFAULT = 6'b000000;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/mccoy_prog_feeder_prog_ram.sv
// DEPTH x IW register-file program memory: synchronous write,
// single combinational read port.
module mccoy_prog_feeder_prog_ram #(
  parameter int DEPTH = 64,
  parameter int IW    = 6,
  parameter int RAW   = 6
) (
  input  logic           clk,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [IW-1:0]  wdata,
  input  logic [RAW-1:0] raddr,
  output logic [IW-1:0]  rdata
);

  logic [IW-1:0] mem_r [DEPTH];

  // Program word storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Zero-latency read for the core's current PC.
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/mccoy_prog_feeder.sv
// Program loader/feeder for the McCoy core: loads a program over a
// valid/ready port, holds the core in reset, then serves instructions by PC.
module mccoy_prog_feeder
  import mccoy_prog_feeder_pkg::*;
#(
  parameter int                DEPTH    = 64,
  parameter int                AW       = MCCOY_AW,
  parameter int                IW       = MCCOY_IW,
  parameter int                RST_HOLD = 2,
  parameter logic [IW-1:0]     FILL     = FILL_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          reload,
  input  logic [AW-1:0] pc_in,
  output logic [IW-1:0] instr_out,
  output logic          core_reset,
  output logic [AW:0]   prog_len,
  output logic          running
);

  localparam int            RAW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [2:0]    HOLD_LAST = 3'(RST_HOLD - 1);

  state_t          state_r, state_s;
  logic [AW-1:0]   wr_ptr_r, wr_ptr_s;
  logic [AW:0]     prog_len_r, prog_len_s;
  logic [2:0]      hold_cnt_r, hold_cnt_s;
  logic            load_ready_r, core_reset_r, running_r;
  logic            we_s;
  logic [IW-1:0]   rdata_s;

  mccoy_prog_feeder_prog_ram #(
    .DEPTH (DEPTH),
    .IW    (IW),
    .RAW   (RAW)
  ) u_prog_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_ptr_r[RAW-1:0]),
    .wdata (load_data),
    .raddr (pc_in[RAW-1:0]),
    .rdata (rdata_s)
  );

  // State, pointers and decoded status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_LOAD;
      wr_ptr_r     <= '0;
      prog_len_r   <= '0;
      hold_cnt_r   <= 3'd0;
      load_ready_r <= 1'b1;
      core_reset_r <= 1'b1;
      running_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      wr_ptr_r     <= wr_ptr_s;
      prog_len_r   <= prog_len_s;
      hold_cnt_r   <= hold_cnt_s;
      load_ready_r <= (state_s == ST_LOAD);
      core_reset_r <= (state_s != ST_RUN);
      running_r    <= (state_s == ST_RUN);
    end
  end

  // Next-state logic; a full memory forces HOLD regardless of load_last.
  always_comb begin
    state_s    = state_r;
    wr_ptr_s   = wr_ptr_r;
    prog_len_s = prog_len_r;
    hold_cnt_s = hold_cnt_r;
    we_s       = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (load_valid) begin
          we_s       = 1'b1;
          wr_ptr_s   = wr_ptr_r + 1'b1;
          prog_len_s = prog_len_r + 1'b1;
          if (load_last || (wr_ptr_r == LAST_ADDR)) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_HOLD: begin
        if (reload) begin
          state_s    = ST_LOAD;
          wr_ptr_s   = '0;
          prog_len_s = '0;
          hold_cnt_s = 3'd0;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s    = ST_RUN;
          hold_cnt_s = 3'd0;
        end else begin
          hold_cnt_s = hold_cnt_r + 3'd1;
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_s    = ST_LOAD;
          wr_ptr_s   = '0;
          prog_len_s = '0;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s    = ST_LOAD;
        wr_ptr_s   = '0;
        prog_len_s = '0;
        hold_cnt_s = 3'd0;
      end
    endcase
  end

  // Instruction mux: combinational so the core sees its word in the PC cycle.
  always_comb begin
    if (running_r && ({1'b0, pc_in} < prog_len_r)) begin
      instr_out = rdata_s;
    end else begin
      instr_out = FILL;
    end
  end

  assign load_ready = load_ready_r;
  assign core_reset = core_reset_r;
  assign running    = running_r;
  assign prog_len   = prog_len_r;

endmodule

// File: tb/tb_mccoy_prog_feeder.sv
// Directed self-checking bench for mccoy_prog_feeder.
module tb_mccoy_prog_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic [5:0] load_data = 6'd0;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       reload = 1'b0;
  logic [5:0] pc_in = 6'd0;
  logic [5:0] instr_out;
  logic       core_reset;
  logic [6:0] prog_len;
  logic       running;

  int tests_run = 0;
  int tests_failed = 0;

  mccoy_prog_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .reload     (reload),
    .pc_in      (pc_in),
    .instr_out  (instr_out),
    .core_reset (core_reset),
    .prog_len   (prog_len),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [5:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if ({load_ready, core_reset, running} !== 3'b110) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 110", {load_ready, core_reset, running});
    end
    tests_run++;
    if (instr_out !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_instr: got %0d expected 0", instr_out);
    end
    tests_run++;
    if (prog_len !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_prog_len: got %0d expected 0", prog_len);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_short_load();
    load_word(6'o15, 1'b0);
    load_word(6'o22, 1'b0);
    load_word(6'o07, 1'b1);
    tests_run++;
    if ({load_ready, core_reset, running} !== 3'b010) begin
      tests_failed++;
      $display("FAIL short_hold1: got %b expected 010", {load_ready, core_reset, running});
    end
    tick();
    tests_run++;
    if ({load_ready, core_reset, running} !== 3'b010) begin
      tests_failed++;
      $display("FAIL short_hold2: got %b expected 010", {load_ready, core_reset, running});
    end
    tick();
    tests_run++;
    if ({load_ready, core_reset, running} !== 3'b001) begin
      tests_failed++;
      $display("FAIL short_run: got %b expected 001", {load_ready, core_reset, running});
    end
    tests_run++;
    if (prog_len !== 7'd3) begin
      tests_failed++;
      $display("FAIL short_prog_len: got %0d expected 3", prog_len);
    end
    pc_in = 6'd1;
    #1;
    tests_run++;
    if (instr_out !== 6'o22) begin
      tests_failed++;
      $display("FAIL short_pc1: got %o expected 22", instr_out);
    end
    pc_in = 6'd0;
    #1;
    tests_run++;
    if (instr_out !== 6'o15) begin
      tests_failed++;
      $display("FAIL short_pc0: got %o expected 15", instr_out);
    end
    pc_in = 6'd2;
    #1;
    tests_run++;
    if (instr_out !== 6'o07) begin
      tests_failed++;
      $display("FAIL short_pc2: got %o expected 07", instr_out);
    end
    pc_in = 6'd3;
    #1;
    tests_run++;
    if (instr_out !== 6'd0) begin
      tests_failed++;
      $display("FAIL short_pc3_fill: got %o expected 0", instr_out);
    end
    pc_in = 6'd5;
    #1;
    tests_run++;
    if (instr_out !== 6'd0) begin
      tests_failed++;
      $display("FAIL short_pc5_fill: got %o expected 0", instr_out);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    load_word(6'o31, 1'b0);
    for (int i = 0; i < 4; i++) begin
      load_data = 6'o77;
      load_last = (i == 2);
      tick();
      tests_run++;
      if (prog_len !== 7'd1 || load_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL gap_idle%0d: got len %0d ready %b expected len 1 ready 1", i, prog_len, load_ready);
      end
    end
    load_last = 1'b0;
    load_word(6'o44, 1'b1);
    tests_run++;
    if (prog_len !== 7'd2) begin
      tests_failed++;
      $display("FAIL gap_prog_len: got %0d expected 2", prog_len);
    end
    tick();
    tick();
    pc_in = 6'd1;
    #1;
    tests_run++;
    if (running !== 1'b1 || instr_out !== 6'o44) begin
      tests_failed++;
      $display("FAIL gap_pc1: got run %b instr %o expected run 1 instr 44", running, instr_out);
    end
    pc_in = 6'd0;
    #1;
    tests_run++;
    if (instr_out !== 6'o31) begin
      tests_failed++;
      $display("FAIL gap_pc0: got %o expected 31", instr_out);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 63; i++) begin
      load_word(6'(i), 1'b0);
    end
    tests_run++;
    if (prog_len !== 7'd63 || load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_63: got len %0d ready %b expected len 63 ready 1", prog_len, load_ready);
    end
    load_valid = 1'b1;
    load_data  = 6'd63;
    tick();
    tests_run++;
    if (prog_len !== 7'd64 || load_ready !== 1'b0 || core_reset !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_64: got len %0d ready %b crst %b expected len 64 ready 0 crst 1", prog_len, load_ready, core_reset);
    end
    load_data = 6'o77;
    tick();
    tick();
    load_valid = 1'b0;
    tests_run++;
    if (prog_len !== 7'd64 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_run: got len %0d run %b expected len 64 run 1", prog_len, running);
    end
    pc_in = 6'd63;
    #1;
    tests_run++;
    if (instr_out !== 6'd63) begin
      tests_failed++;
      $display("FAIL full_pc63: got %0d expected 63", instr_out);
    end
    pc_in = 6'd10;
    #1;
    tests_run++;
    if (instr_out !== 6'd10) begin
      tests_failed++;
      $display("FAIL full_pc10: got %0d expected 10", instr_out);
    end
  endtask

  task automatic test_reload();
    pc_in  = 6'd63;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    tests_run++;
    if ({load_ready, core_reset, running} !== 3'b110 || prog_len !== 7'd0 || instr_out !== 6'd0) begin
      tests_failed++;
      $display("FAIL reload_state: got flags %b len %0d instr %0d expected 110 0 0", {load_ready, core_reset, running}, prog_len, instr_out);
    end
    reload = 1'b1;
    tick();
    reload = 1'b0;
    tests_run++;
    if (load_ready !== 1'b1 || prog_len !== 7'd0) begin
      tests_failed++;
      $display("FAIL reload_in_load: got ready %b len %0d expected 1 0", load_ready, prog_len);
    end
    load_word(6'o52, 1'b1);
    tick();
    tick();
    pc_in = 6'd0;
    #1;
    tests_run++;
    if (running !== 1'b1 || instr_out !== 6'o52) begin
      tests_failed++;
      $display("FAIL reload_pc0: got run %b instr %o expected run 1 instr 52", running, instr_out);
    end
    pc_in = 6'd1;
    #1;
    tests_run++;
    if (instr_out !== 6'd0) begin
      tests_failed++;
      $display("FAIL reload_pc1_fill: got %o expected 0", instr_out);
    end
  endtask

  task automatic test_reload_hold();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    load_word(6'o11, 1'b1);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    tests_run++;
    if ({load_ready, core_reset, running} !== 3'b110 || prog_len !== 7'd0) begin
      tests_failed++;
      $display("FAIL reload_hold: got flags %b len %0d expected 110 0", {load_ready, core_reset, running}, prog_len);
    end
  endtask

  task automatic test_reset_hold();
    load_word(6'o33, 1'b1);
    tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if ({load_ready, core_reset, running} !== 3'b110 || prog_len !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: got flags %b len %0d expected 110 0", {load_ready, core_reset, running}, prog_len);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    tests_run++;
    if ({load_ready, core_reset, running} !== 3'b110) begin
      tests_failed++;
      $display("FAIL reset_hold_stays_load: got %b expected 110", {load_ready, core_reset, running});
    end
  endtask

  initial begin
    test_reset();
    test_short_load();
    test_backpressure();
    test_full();
    test_reload();
    test_reload_hold();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mccoy_prog_feeder.md
Name: mccoy_prog_feeder

Overview:
- Upstream instruction source for the McCoy core.
- Accepts a program of 6-bit instruction words over a valid/ready load port and stores them in a small register-file program memory.
- Holds the core in reset while loading. Afterwards it supplies the instruction at the core's current PC each cycle, so it drives the core's io_in[5:0] and reset bit.

Parameters:
- DEPTH, 64, number of program words (power of two, max 64).
- AW, 6, address width; equals the core PC width.
- IW, 6, instruction width; equals io_in[5:0].
- RST_HOLD, 2, cycles core_reset stays high after load completes (1..7).
- FILL, 6'b000000, word returned for unloaded addresses and while not running.

Ports:
- clk  input  1  system clock, same net as core io_in[7].
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  IW  instruction word to store.
- load_last  input  1  marks the final word of the program; qualified by the load handshake.
- load_ready  output  1  block accepts a load word this cycle.
- reload  input  1  single-cycle request to abandon RUN and restart loading.
- pc_in  input  AW  core program counter, supplied directly by the top level (not the muxed io_out).
- instr_out  output  IW  instruction to the core, io_in[5:0].
- core_reset  output  1  reset to the core, io_in[6].
- prog_len  output  AW+1  number of words loaded, 0..DEPTH.
- running  output  1  high in RUN.

Behaviour:
- Reset is asynchronous and active-high. On reset, all outputs and state take these values:
  - state=LOAD, wr_ptr=0, prog_len=0, hold_cnt=0;
  - load_ready=1, core_reset=1, running=0, instr_out=FILL.
  - Memory contents are not reset; prog_len gates every read.
- States: LOAD, HOLD, RUN. All state and count registers update on posedge clk.
- LOAD:
  - load_ready=1, core_reset=1, instr_out=FILL.
  - A word is accepted when load_valid && load_ready: mem[wr_ptr]<=load_data, wr_ptr<=wr_ptr+1, prog_len<=prog_len+1.
  - Go to HOLD when the accepted word has load_last=1, or when it is the word at wr_ptr==DEPTH-1 (full). Full forces HOLD regardless of load_last.
  - load_last without load_valid is ignored.
- HOLD:
  - load_ready=0, core_reset=1, hold_cnt increments each cycle.
  - When hold_cnt==RST_HOLD-1, go to RUN and clear hold_cnt.
  - Exactly RST_HOLD cycles in HOLD.
- RUN:
  - load_ready=0, core_reset=0, running=1.
  - instr_out is combinational: mem[pc_in] if pc_in < prog_len, else FILL. This is zero-latency, because the core consumes io_in in the same cycle its PC is presented.
  - pc_in wrap from 63 to 0 needs no special handling.
- reload=1 in RUN or HOLD: next state LOAD; wr_ptr=0, prog_len=0, core_reset=1 in the following cycle. reload is ignored in LOAD.
- Simultaneous events:
  - reload with a load handshake: not possible, since load_ready=0 outside LOAD.
  - load_last on the full word: single transition to HOLD.
  - Empty program: impossible, because exit from LOAD requires an accepted word, so prog_len>=1 in RUN.
- Reset mid-load or mid-run: immediate return to reset values. A partially loaded program is discarded via prog_len=0.
- Memory write port is active only in LOAD. The read port is combinational and single.

Decomposition:
- Shared package holds:
  - state encoding (LOAD=2'd0, HOLD=2'd1, RUN=2'd2);
  - McCoy word widths (IW=6, AW=6);
  - default FILL.
- One natural sub-module, prog_ram: DEPTH x IW register file, synchronous write, combinational read.
- The FSM, pointers and hold counter stay in the top module.

Test Plan:
- Reset values: assert reset mid-cycle -> immediately load_ready=1, core_reset=1, running=0, instr_out=0, prog_len=0.
- Short load then run:
  - load 3 words 6'o15, 6'o22, 6'o07 with load_last on the third -> 2 cycles HOLD (core_reset=1), then running=1, core_reset=0.
  - pc_in=1 -> instr_out=6'o22; pc_in=5 -> instr_out=FILL.
- Backpressure gaps: load_valid deasserted for 4 cycles between words -> no writes, prog_len unchanged; the next valid word lands at the next address.
- Full without load_last: load 64 words (value = index) -> HOLD after the 64th, prog_len=64; pc_in=63 -> instr_out=63; further load_valid is not accepted.
- Reload in RUN: pulse reload -> next cycle core_reset=1, load_ready=1, prog_len=0, instr_out=FILL; reload of 1 word with load_last -> RUN; pc_in=0 returns the new word.
- Reset during HOLD: hold_cnt=1 and reset asserted -> LOAD immediately, core_reset stays 1, prog_len=0.
